// File: rtl/dh_gun_pkg.sv
// -----------------------------------------------------------------------------
// dh_gun_pkg
// Shared types and constants for the light-gun front end.
//   gun_state_t          : shot-sequence FSM states
//   FRAME_CNT_W          : width of the frame_start counter (frames 1..3)
//   DEF_*                : default timing for a 65 MHz pixel clock
//   cnt_width()          : width of a counter that counts 0..n-1
// -----------------------------------------------------------------------------
package dh_gun_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        BLANK,
        FLASH,
        RESULT,
        HOLDOFF
    } gun_state_t;

    localparam int unsigned FRAME_CNT_W         = 2;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 650_000;    // 10 ms
    localparam int unsigned DEF_BLANK_FRAMES    = 1;
    localparam int unsigned DEF_FLASH_FRAMES    = 1;
    localparam int unsigned DEF_HOLDOFF_CYCLES  = 3_250_000;  // 50 ms

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gun_debounce.sv
// -----------------------------------------------------------------------------
// gun_debounce
// 2-FF synchroniser followed by a level debouncer. The stable level follows
// the synchronised input only after it has disagreed for DEBOUNCE_CYCLES
// consecutive cycles; any agreeing cycle restarts the count.
// Ports:
//   clk, rst_n (sync, active-low)
//   din_raw     : asynchronous input pin
//   stable      : debounced level (RESET_LEVEL after reset)
// -----------------------------------------------------------------------------
module gun_debounce
    import dh_gun_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic        RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_raw,
    output logic stable
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync   <= {2{RESET_LEVEL}};
            stable <= RESET_LEVEL;
            cnt    <= '0;
        end else begin
            sync <= {sync[0], din_raw};
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gun_shot_ctrl.sv
// -----------------------------------------------------------------------------
// gun_shot_ctrl
// Light-gun front end: debounces the trigger, synchronises the photodetector
// and runs the Zapper-style shot sequence (black frame(s), white target
// frame(s), hit/miss report).
// Ports:
//   clk, rst_n            : 65 MHz clock, synchronous active-low reset
//   gun_trigger_raw       : async trigger pin, low = pressed
//   gun_photodetector_raw : async detector pin, high = light seen
//   frame_start           : 1-cycle pulse at start of active video
//   pause, ammo_ok        : game status
//   blank_req, flash_req  : renderer overlay requests (registered)
//   shot_fired, hit, miss : 1-cycle pulses to score/ammo logic
//   busy                  : high whenever the FSM is not IDLE
// Build option: GUN_AMBIENT_CHECK_EN enables the BLANK frame(s) and the
// ambient-light check; without it WAIT_FRAME goes straight to FLASH.
// -----------------------------------------------------------------------------
module gun_shot_ctrl
    import dh_gun_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned BLANK_FRAMES    = DEF_BLANK_FRAMES,
    parameter int unsigned FLASH_FRAMES    = DEF_FLASH_FRAMES,
    parameter int unsigned HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic gun_trigger_raw,
    input  logic gun_photodetector_raw,
    input  logic frame_start,
    input  logic pause,
    input  logic ammo_ok,
    output logic blank_req,
    output logic flash_req,
    output logic shot_fired,
    output logic hit,
    output logic miss,
    output logic busy
);

    localparam int unsigned HOLD_W = cnt_width(HOLDOFF_CYCLES);

    gun_state_t state_q, state_d;

    logic                   trig_stable;   // 1 = released
    logic                   trig_stable_d;
    logic                   press;
    logic [1:0]             det_sync;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic [HOLD_W-1:0]      hold_cnt;
    logic                   hold_done;
    logic                   seen;
    logic                   seen_next;
    logic                   ambient_now;
    logic                   blank_d, flash_d, shot_d, hit_d, miss_d, busy_d;

    gun_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (1'b1)
    ) u_trig_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .din_raw (gun_trigger_raw),
        .stable  (trig_stable)
    );

    // Released-to-pressed edge of the debounced level.
    assign press     = trig_stable_d & ~trig_stable;
    assign hold_done = (hold_cnt == HOLD_W'(HOLDOFF_CYCLES - 1));
    // Include the current cycle's sample so the last FLASH cycle counts.
    assign seen_next = seen | ((state_q == FLASH) & det_sync[1]);

`ifdef GUN_AMBIENT_CHECK_EN
    logic ambient;
    assign ambient_now = ambient;
`else
    assign ambient_now = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            blank_req  <= 1'b0;
            flash_req  <= 1'b0;
            shot_fired <= 1'b0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            blank_req  <= blank_d;
            flash_req  <= flash_d;
            shot_fired <= shot_d;
            hit        <= hit_d;
            miss       <= miss_d;
            busy       <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (press && !pause && ammo_ok) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (pause) begin
                    state_d = HOLDOFF;
                end else if (frame_start) begin
`ifdef GUN_AMBIENT_CHECK_EN
                    state_d = BLANK;
`else
                    state_d = FLASH;
`endif
                end
            end
            BLANK: begin
                if (pause) begin
                    state_d = HOLDOFF;
                end else if (frame_start &&
                             frame_cnt == FRAME_CNT_W'(BLANK_FRAMES - 1)) begin
                    state_d = FLASH;
                end
            end
            FLASH: begin
                if (pause) begin
                    state_d = HOLDOFF;
                end else if (frame_start &&
                             frame_cnt == FRAME_CNT_W'(FLASH_FRAMES - 1)) begin
                    state_d = RESULT;
                end
            end
            RESULT: begin
                state_d = HOLDOFF;
            end
            HOLDOFF: begin
                // Waiting for release makes a held trigger fire only once.
                if (hold_done && trig_stable) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic (values registered on the next edge)
    always_comb begin
        blank_d = 1'b0;
        flash_d = (state_d == FLASH);
        shot_d  = (state_q == WAIT_FRAME) && !pause && frame_start;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        busy_d  = (state_d != IDLE);
`ifdef GUN_AMBIENT_CHECK_EN
        blank_d = (state_d == BLANK);
`endif
        if (state_q == FLASH && state_d == RESULT) begin
            hit_d  = seen_next & ~ambient_now;
            miss_d = ~(seen_next & ~ambient_now);
        end
    end

    // Datapath: synchroniser, press edge, frame/holdoff counters, flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trig_stable_d <= 1'b1;
            det_sync      <= '0;
            frame_cnt     <= '0;
            hold_cnt      <= '0;
            seen          <= 1'b0;
`ifdef GUN_AMBIENT_CHECK_EN
            ambient       <= 1'b0;
`endif
        end else begin
            trig_stable_d <= trig_stable;
            det_sync      <= {det_sync[0], gun_photodetector_raw};
            unique case (state_q)
                WAIT_FRAME: begin
                    frame_cnt <= '0;
                    seen      <= 1'b0;
`ifdef GUN_AMBIENT_CHECK_EN
                    ambient   <= 1'b0;
`endif
                end
                BLANK: begin
`ifdef GUN_AMBIENT_CHECK_EN
                    if (det_sync[1]) ambient <= 1'b1;
`endif
                    if (frame_start) begin
                        frame_cnt <= (state_d == FLASH) ? '0 : frame_cnt + 1'b1;
                    end
                end
                FLASH: begin
                    if (det_sync[1]) seen <= 1'b1;
                    if (frame_start) frame_cnt <= frame_cnt + 1'b1;
                end
                HOLDOFF: begin
                    if (!hold_done) hold_cnt <= hold_cnt + 1'b1;
                end
                default: begin
                end
            endcase
            if (state_d == HOLDOFF && state_q != HOLDOFF) hold_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_gun_shot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gun_shot_ctrl
// Directed bench for gun_shot_ctrl with a sequential reference model and
// per-cycle output comparison, plus scenario-level pulse/cycle counts.
// -----------------------------------------------------------------------------
module tb_gun_shot_ctrl;

    localparam int DB    = 4;
    localparam int HOLD  = 8;
    localparam int NBLK  = 1;
    localparam int NFLS  = 1;
    localparam int FPER  = 50;
`ifdef GUN_AMBIENT_CHECK_EN
    localparam int AMB = 1;
`else
    localparam int AMB = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic gun_trigger_raw = 1'b1;
    logic gun_photodetector_raw = 1'b0;
    logic frame_start = 1'b0;
    logic pause = 1'b0;
    logic ammo_ok = 1'b1;
    logic blank_req, flash_req, shot_fired, hit, miss, busy;

    int checks = 0;
    int errors = 0;

    gun_shot_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .BLANK_FRAMES    (NBLK),
        .FLASH_FRAMES    (NFLS),
        .HOLDOFF_CYCLES  (HOLD)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .gun_trigger_raw       (gun_trigger_raw),
        .gun_photodetector_raw (gun_photodetector_raw),
        .frame_start           (frame_start),
        .pause                 (pause),
        .ammo_ok               (ammo_ok),
        .blank_req             (blank_req),
        .flash_req             (flash_req),
        .shot_fired            (shot_fired),
        .hit                   (hit),
        .miss                  (miss),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame strobe: one cycle every FPER cycles.
    initial begin
        int n = 0;
        forever begin
            @(posedge clk); #1;
            n++;
            frame_start = (n % FPER == 0);
        end
    end

    // ---------------- reference model ----------------
    // Phases of one shot, walked through as a sequence of events.
    localparam int PH_IDLE = 0, PH_WAIT = 1, PH_BLANK = 2, PH_FLASH = 3,
                   PH_RES = 4, PH_HOLD = 5;
    int phase = PH_IDLE;
    int t1 = 1, t2 = 1, d1 = 0, d2 = 0;   // 2-stage pin delay lines
    int stab = 1, run = 0, pressed = 0;
    int amb = 0, seen = 0, frames = 0, hcnt = 0;
    int m_blank = 0, m_flash = 0, m_shot = 0, m_hit = 0, m_miss = 0, m_busy = 0;
    bit model_valid = 0;

    initial begin
        forever begin
            @(posedge clk);
            m_shot = 0; m_hit = 0; m_miss = 0;
            if (!rst_n) begin
                phase = PH_IDLE; t1 = 1; t2 = 1; d1 = 0; d2 = 0;
                stab = 1; run = 0; pressed = 0;
                amb = 0; seen = 0; frames = 0; hcnt = 0;
            end else begin
                case (phase)
                    PH_IDLE:
                        if (pressed == 1 && !pause && ammo_ok) phase = PH_WAIT;
                    PH_WAIT:
                        if (pause) begin phase = PH_HOLD; hcnt = 0; end
                        else if (frame_start) begin
                            m_shot = 1; amb = 0; seen = 0; frames = 0;
                            phase = (AMB == 1) ? PH_BLANK : PH_FLASH;
                        end
                    PH_BLANK:
                        if (pause) begin phase = PH_HOLD; hcnt = 0; end
                        else begin
                            if (d2 == 1) amb = 1;
                            if (frame_start) begin
                                frames++;
                                if (frames == NBLK) begin frames = 0; phase = PH_FLASH; end
                            end
                        end
                    PH_FLASH:
                        if (pause) begin phase = PH_HOLD; hcnt = 0; end
                        else begin
                            if (d2 == 1) seen = 1;
                            if (frame_start) begin
                                frames++;
                                if (frames == NFLS) begin
                                    phase  = PH_RES;
                                    m_hit  = (seen == 1 && amb == 0) ? 1 : 0;
                                    m_miss = 1 - m_hit;
                                end
                            end
                        end
                    PH_RES: begin phase = PH_HOLD; hcnt = 0; end
                    default: begin
                        hcnt++;
                        if (hcnt >= HOLD && stab == 1) phase = PH_IDLE;
                    end
                endcase
                pressed = 0;
                if (t2 != stab) begin
                    run++;
                    if (run == DB) begin run = 0; stab = t2; pressed = (t2 == 0); end
                end else begin
                    run = 0;
                end
                t2 = t1; t1 = int'(gun_trigger_raw);
                d2 = d1; d1 = int'(gun_photodetector_raw);
            end
            m_blank = (phase == PH_BLANK);
            m_flash = (phase == PH_FLASH);
            m_busy  = (phase != PH_IDLE);
            model_valid = 1;
        end
    end

    // ---------------- compare + pulse counters ----------------
    int n_shot = 0, n_hit = 0, n_miss = 0, n_blank = 0, n_flash = 0, n_busy = 0;

    always @(negedge clk) begin
        if (model_valid) begin
            check("blank_req", int'(blank_req), m_blank);
            check("flash_req", int'(flash_req), m_flash);
            check("shot_fired", int'(shot_fired), m_shot);
            check("hit", int'(hit), m_hit);
            check("miss", int'(miss), m_miss);
            check("busy", int'(busy), m_busy);
            check("overlap", int'(blank_req & flash_req), 0);
        end
        n_shot  += int'(shot_fired);
        n_hit   += int'(hit);
        n_miss  += int'(miss);
        n_blank += int'(blank_req);
        n_flash += int'(flash_req);
        n_busy  += int'(busy);
    end

    // ---------------- stimulus helpers ----------------
    int s_shot, s_hit, s_miss, s_blank, s_flash, s_busy;

    task automatic snap();
        s_shot = n_shot; s_hit = n_hit; s_miss = n_miss;
        s_blank = n_blank; s_flash = n_flash; s_busy = n_busy;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic press_for(input int n);
        gun_trigger_raw = 1'b0;
        cycles(n);
        gun_trigger_raw = 1'b1;
    endtask

    function automatic int sig(input int which);
        case (which)
            0: return int'(flash_req);
            1: return int'(blank_req);
            2: return int'(hit | miss);
            default: return int'(busy);
        endcase
    endfunction

    task automatic wait_until(input int which, input int level, input int maxc,
                              input string name);
        int n = 0;
        while (sig(which) != level) begin
            if (n >= maxc) begin
                check({name, " timeout"}, sig(which), level);
                return;
            end
            @(posedge clk); #2;
            n++;
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        cycles(4);
        check("reset outputs", int'({blank_req, flash_req, shot_fired, hit, miss, busy}), 0);
        rst_n = 1'b1;
        cycles(20);

        // A: 3-cycle glitch is rejected
        snap();
        press_for(3);
        cycles(40);
        check("A shots", n_shot - s_shot, 0);
        check("A busy cycles", n_busy - s_busy, 0);

        // B: clean shot, light only during FLASH -> hit
        snap();
        press_for(20);
        wait_until(0, 1, 200, "B flash rise");
        cycles(10);
        gun_photodetector_raw = 1'b1;
        cycles(5);
        gun_photodetector_raw = 1'b0;
        wait_until(2, 1, 100, "B result");
        wait_until(3, 0, 100, "B idle");
        check("B shots", n_shot - s_shot, 1);
        check("B hits", n_hit - s_hit, 1);
        check("B misses", n_miss - s_miss, 0);
        check("B blank cycles", n_blank - s_blank, 50 * AMB);
        check("B flash cycles", n_flash - s_flash, 50);
        cycles(5);

        // C: light during BLANK and FLASH -> miss with ambient check, else hit
        snap();
        gun_photodetector_raw = 1'b1;
        press_for(20);
        wait_until(2, 1, 200, "C result");
        gun_photodetector_raw = 1'b0;
        wait_until(3, 0, 100, "C idle");
        check("C hits", n_hit - s_hit, 1 - AMB);
        check("C misses", n_miss - s_miss, AMB);
        check("C blank cycles", n_blank - s_blank, 50 * AMB);
        cycles(5);

        // D: pause mid-FLASH aborts with no result
        snap();
        press_for(20);
        wait_until(0, 1, 200, "D flash rise");
        cycles(10);
        pause = 1'b1;
        @(posedge clk); #2;
        check("D flash after pause", int'(flash_req), 0);
        check("D busy after pause", int'(busy), 1);
        cycles(3);
        pause = 1'b0;
        wait_until(3, 0, 50, "D idle");
        check("D shots", n_shot - s_shot, 1);
        check("D results", (n_hit - s_hit) + (n_miss - s_miss), 0);
        cycles(5);

        // E: held trigger fires once; re-press fires again
        snap();
        press_for(500);
        check("E busy while held", int'(busy), 1);
        wait_until(3, 0, 50, "E idle");
        check("E shots held", n_shot - s_shot, 1);
        snap();
        press_for(20);
        wait_until(3, 1, 50, "E2 busy");
        wait_until(3, 0, 300, "E2 idle");
        check("E shots repress", n_shot - s_shot, 1);
        cycles(5);

        // F: no ammo, and press during pause, are both discarded
        snap();
        ammo_ok = 1'b0;
        press_for(20);
        cycles(100);
        ammo_ok = 1'b1;
        pause = 1'b1;
        press_for(20);
        cycles(30);
        pause = 1'b0;
        cycles(100);
        check("F shots", n_shot - s_shot, 0);
        check("F busy cycles", n_busy - s_busy, 0);

        // G: reset mid-BLANK (mid-FLASH without ambient check)
        press_for(20);
        wait_until(AMB == 1 ? 1 : 0, 1, 200, "G overlay rise");
        cycles(5);
        rst_n = 1'b0;
        @(posedge clk); #2;
        check("G outputs after reset",
              int'({blank_req, flash_req, shot_fired, hit, miss, busy}), 0);
        #1;
        rst_n = 1'b1;
        cycles(30);
        check("G busy after reset", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
